// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with valid/ready handshaking on
// both sides, result flags and a user tag that travels with each operation.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        operation offered
//   in_ready        operation accepted this cycle (combinational from out_ready)
//   a, b            operands (unsigned; signed interpretation only for ovf)
//   op_type         0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 mul(low)
//   tag             user tag, returned unchanged as c_tag
//   out_valid       result available (driven straight from stage 2)
//   out_ready       consumer accepts the result
//   c, c_tag        result and its tag
//   carry           carry (add) / borrow (sub) / high half nonzero (mul)
//   zero            c == 0
//   ovf             signed overflow (add/sub only)
//
// The op-code port of the behavioural model was named "type", which is a
// reserved word in SystemVerilog; it is exposed here as op_type.

module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_type,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [TAG_W-1:0] c_tag,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  // Stage 1: captured operation
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: registered result (drives the outputs)
  logic             s2_valid;
  logic [WIDTH-1:0] s2_c;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_carry;
  logic             s2_zero;
  logic             s2_ovf;

  logic adv1;
  logic adv2;

  // Each stage advances when it is empty or the stage after it advances,
  // so a full pipe with out_ready high keeps streaming without a bubble.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_tag   <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_op  <= op_e'(op_type);
        s1_tag <= tag;
      end
    end
  end

  // Stage-1 datapath
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       dif;
  logic [2*WIDTH-1:0]   prod;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     r_c;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_ovf;

  assign sum   = {1'b0, s1_a} + {1'b0, s1_b};
  assign dif   = {1'b0, s1_a} - {1'b0, s1_b};
  assign prod  = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
  assign shamt = s1_b[SHW-1:0];

  always_comb begin
    r_c     = '0;
    r_carry = 1'b0;
    r_ovf   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        r_c     = sum[WIDTH-1:0];
        r_carry = sum[WIDTH];
        r_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        r_c     = dif[WIDTH-1:0];
        r_carry = dif[WIDTH];
        r_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                  (dif[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND: r_c = s1_a & s1_b;
      OP_OR:  r_c = s1_a | s1_b;
      OP_XOR: r_c = s1_a ^ s1_b;
      OP_SHL: r_c = s1_a << shamt;
      OP_SHR: r_c = s1_a >> shamt;
      OP_MUL: begin
        r_c     = prod[WIDTH-1:0];
        r_carry = |prod[2*WIDTH-1:WIDTH];
      end
      default: r_c = '0;
    endcase
    r_zero = (r_c == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_tag   <= '0;
      s2_carry <= 1'b0;
      s2_zero  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c     <= r_c;
        s2_tag   <= s1_tag;
        s2_carry <= r_carry;
        s2_zero  <= r_zero;
        s2_ovf   <= r_ovf;
      end
    end
  end

  assign out_valid = s2_valid;
  assign c         = s2_c;
  assign c_tag     = s2_tag;
  assign carry     = s2_carry;
  assign zero      = s2_zero;
  assign ovf       = s2_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32, TAG_W=4): directed vectors with
// literal expectations plus a queue-based reference model checked on every
// output transfer.

module tb_alu_pipe;

  localparam int W      = 32;
  localparam int TW     = 4;
  localparam int N_RAND = 10000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op_type;
  logic [TW-1:0] tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c;
  logic [TW-1:0] c_tag;
  logic          carry;
  logic          zero;
  logic          ovf;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_type(op_type), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .c_tag(c_tag), .carry(carry), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  c;
    logic          cy;
    logic          z;
    logic          o;
  } res_t;

  res_t q[$];
  res_t held;
  res_t exp_r;
  logic stall = 1'b0;
  int   n_acc = 0;
  int   n_out = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operation's definition.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] t, input logic [TW-1:0] g);
    res_t r;
    longint unsigned u;
    longint s;
    r = '0;
    r.tag = g;
    case (t)
      3'd0: begin
        u = 64'(x) + 64'(y);
        r.c = u[31:0];
        r.cy = (u > 64'h0000_0000_FFFF_FFFF);
        s = longint'($signed(x)) + longint'($signed(y));
        r.o = (s != longint'($signed(r.c)));
      end
      3'd1: begin
        r.c = x - y;
        r.cy = (x < y);
        s = longint'($signed(x)) - longint'($signed(y));
        r.o = (s != longint'($signed(r.c)));
      end
      3'd2: r.c = x & y;
      3'd3: r.c = x | y;
      3'd4: r.c = x ^ y;
      3'd5: r.c = x << (y % 32);
      3'd6: r.c = x >> (y % 32);
      default: begin
        u = 64'(x) * 64'(y);
        r.c = u[31:0];
        r.cy = ((u >> 32) != 0);
      end
    endcase
    r.z = (r.c == 0);
    return r;
  endfunction

  // Compare process: sampled on the falling edge, i.e. the values that the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall = 1'b0;
      chk("in_ready_during_rst", in_ready, 0);
    end else begin
      if (stall)
        chk("stall_stable", {out_valid, c_tag, c, carry, zero, ovf}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0)
          chk("spurious_out_valid", out_valid, 0);
        else begin
          exp_r = q.pop_front();
          chk("result", {c_tag, c, carry, zero, ovf}, exp_r);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, op_type, tag));
        n_acc++;
      end
      stall = out_valid && !out_ready;
      held  = {c_tag, c, carry, zero, ovf};
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return W'($urandom_range(0, 15));
      2: return 32'hFFFF_FFFF - W'($urandom_range(0, 15));
      default: return 32'h8000_0000 ^ W'($urandom_range(0, 15));
    endcase
  endfunction

  // Directed vectors: a, b, op, expected c, carry, zero, ovf
  localparam int NV = 11;
  logic [W-1:0] va [NV] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3, 32'd1, 32'h8000_0000,
                            32'h0001_0000, 32'h8000_0000, 32'h0000_F0F0, 32'd5, 32'h1234, 32'd6};
  logic [W-1:0] vb [NV] = '{32'd1, 32'd1, 32'd5, 32'd33, 32'd31,
                            32'h0001_0000, 32'd1, 32'h0000_0FF0, 32'hA, 32'h1234, 32'd7};
  logic [2:0]   vt [NV] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  logic [W-1:0] vc [NV] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'd2, 32'd1,
                            32'h0, 32'h7FFF_FFFF, 32'h0000_00F0, 32'hF, 32'h0, 32'h2A};
  logic [2:0]   vf [NV] = '{3'b110, 3'b001, 3'b100, 3'b000, 3'b000,
                            3'b110, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000};

  int acc;
  int base;
  int cyc;
  logic [W-1:0] c_snap;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op_type = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_c_tag", c_tag, 0);
    chk("rst_flags", {carry, zero, ovf}, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Streamed adds: item k offered before edge k, visible after edge k+1.
    out_ready = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e < 10) begin
        in_valid = 1'b1; a = W'(e); b = W'(2 * e); op_type = 3'd0; tag = TW'(e);
      end else
        in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stream_valid", out_valid, (e >= 1 && e <= 10));
      if (e >= 1 && e <= 10) begin
        chk("stream_c", c, 3 * (e - 1));
        chk("stream_tag", c_tag, e - 1);
      end
    end

    // Directed vectors, one at a time; model is pinned against the literals.
    for (int i = 0; i < NV; i++) begin
      chk("model_pin", model(va[i], vb[i], vt[i], TW'(i)), {TW'(i), vc[i], vf[i]});
      in_valid = 1'b1; a = va[i]; b = vb[i]; op_type = vt[i]; tag = TW'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("vec_valid", out_valid, 1);
      chk("vec_c", c, vc[i]);
      chk("vec_flags", {carry, zero, ovf}, vf[i]);
      chk("vec_tag", c_tag, i);
    end
    @(posedge clk); #1;

    // Backpressure: 5 cycles of offers with out_ready low.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = W'(100 + i); b = W'(i); op_type = 3'd0; tag = TW'(i);
      #1;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_c", c, 100);
    chk("bp_hold_tag", c_tag, 0);
    c_snap = c;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_c_stable", c, c_snap);
    in_valid = 1'b0;
    base = n_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drain_c2", c, 102);
    chk("bp_drain_tag2", c_tag, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_drain_count", n_out - base, 2);
    chk("bp_drain_empty", out_valid, 0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = W'(40 + i); b = 32'd1; op_type = 3'd0; tag = TW'(9 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_out", out_valid, 0);
    end
    in_valid = 1'b1; a = 32'd5; b = 32'd6; op_type = 3'd0; tag = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("postrst_lat_early", out_valid, 0);
    @(posedge clk); #1;
    chk("postrst_valid", out_valid, 1);
    chk("postrst_c", c, 11);
    chk("postrst_tag", c_tag, 7);
    @(posedge clk); #1;

    // Random traffic against the model.
    base = n_acc;
    cyc = 0;
    while (n_acc - base < N_RAND && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); op_type = 3'($urandom_range(0, 7)); tag = TW'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_accepts_reached", (n_acc - base >= N_RAND), 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("random_drained", q.size(), 0);
    chk("random_out_valid_low", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
